// File: rtl/prog_loader.sv
// prog_loader: boot sequencer that streams a program into instr_mem/data_memory,
// holds the cpu in reset while loading, then hands the data port to the cpu.
module prog_loader #(
    parameter int         INSTR_MEM_SIZE_BYTES = 1024,
    parameter int         MEM_SIZE_BYTES       = 1024,
    parameter int         BOOT_HOLD_CYCLES     = 4,
    parameter logic [2:0] LOAD_OP              = 3'b010
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        cpu_resetn,
    output logic        imem_wr_en,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        cpu_mem_wr_en,
    input  logic [2:0]  cpu_mem_op,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_data_in,
    output logic        mem_wr_en,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int          CAP_I     = INSTR_MEM_SIZE_BYTES < MEM_SIZE_BYTES ? INSTR_MEM_SIZE_BYTES : MEM_SIZE_BYTES;
    localparam logic [31:0] CAP       = 32'(CAP_I);
    localparam int          HW        = $clog2(BOOT_HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(BOOT_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t        state, state_n;
    logic [31:0]   addr, wr_addr, wr_data;
    logic [HW-1:0] hold_cnt;
    logic          wr_pend, accept, fits, start, run;

    assign run    = state == RUN;
    assign accept = state == LOAD && s_valid;
    assign start  = load_start && (state == IDLE || run);
    // addr never advances past CAP, so addr + 4 cannot overflow
    assign fits   = (addr + 32'd4) <= CAP;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load_start ? LOAD : IDLE;
            LOAD:    state_n = accept && s_last ? HOLD : LOAD;
            HOLD:    state_n = hold_cnt == HOLD_LAST ? RUN : HOLD;
            default: state_n = load_start ? LOAD : RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            addr     <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_pend  <= 1'b0;
            hold_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            wr_pend  <= accept && fits;
            hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
            if (accept && fits) begin
                wr_addr <= addr;
                wr_data <= s_data;
                addr    <= addr + 32'd4;
            end
            if (accept && !fits)
                err <= 1'b1;
            if (start) begin
                addr <= '0;
                err  <= 1'b0;
            end
        end
    end

    assign s_ready     = state == LOAD;
    assign cpu_resetn  = run;
    assign done        = run;
    assign busy        = state == LOAD || state == HOLD;
    assign imem_wr_en  = wr_pend;
    assign imem_addr   = wr_addr;
    assign imem_wdata  = wr_data;
    assign mem_wr_en   = run ? cpu_mem_wr_en   : wr_pend;
    assign mem_op      = run ? cpu_mem_op      : LOAD_OP;
    assign mem_addr    = run ? cpu_mem_addr    : wr_addr;
    assign mem_data_in = run ? cpu_mem_data_in : wr_data;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of prog_loader with a small imem/dmem model
// that records every write strobe.
module tb_prog_loader;
    logic        clk = 0, resetn = 0, load_start = 0, s_valid = 0, s_last = 0;
    logic [31:0] s_data = 0;
    logic        cpu_mem_wr_en = 0;
    logic [2:0]  cpu_mem_op = 0;
    logic [31:0] cpu_mem_addr = 0, cpu_mem_data_in = 0;
    logic        s_ready, cpu_resetn, imem_wr_en, mem_wr_en, busy, done, err;
    logic [31:0] imem_addr, imem_wdata, mem_addr, mem_data_in;
    logic [2:0]  mem_op;

    int n_cmp = 0, n_fail = 0;

    logic [31:0] imem_m [256];
    logic [7:0]  dmem_m [1024];
    logic [31:0] wa_q[$], wd_q[$];

    prog_loader dut (
        .clk(clk), .resetn(resetn), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cpu_resetn(cpu_resetn), .imem_wr_en(imem_wr_en), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_mem_wr_en(cpu_mem_wr_en), .cpu_mem_op(cpu_mem_op),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_data_in(cpu_mem_data_in),
        .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_wr_en) begin
            imem_m[imem_addr[9:2]] <= imem_wdata;
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (mem_wr_en && mem_addr < 32'd1024) begin
            if (mem_op == 3'b010)
                for (int b = 0; b < 4; b++) dmem_m[mem_addr[9:0] + 10'(b)] <= mem_data_in[8*b +: 8];
            else
                dmem_m[mem_addr[9:0]] <= mem_data_in[7:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1;
        @(posedge clk); #1;
        load_start = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int k = 0;
        s_valid = 1; s_data = d; s_last = l;
        while (!s_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (k == 20) chk("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 0; s_last = 0;
    endtask

    task automatic wait_run(input string nm);
        int k = 0;
        while (!done && k < 50) begin @(posedge clk); #1; k++; end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic wr; logic [2:0] op; logic [31:0] addr, data;
        logic exp_wr; logic [2:0] exp_op; logic [31:0] exp_addr, exp_data;
    } vec_t;

    logic [31:0] prog [3];

    initial begin
        vec_t tbl [4];
        int   k;
        tbl[0] = '{1'b1, 3'b000, 32'd512,       32'h0000_0069, 1'b1, 3'b000, 32'd512,       32'h0000_0069};
        tbl[1] = '{1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678};
        tbl[2] = '{1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 3'b001, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'hA5A5_A5A5};
        prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_imem_wr_en", {31'd0, imem_wr_en}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        resetn = 1;
        @(posedge clk); #1;
        chk("idle_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);

        // basic 3-word load and hold timing
        pulse_start();
        chk("load_busy_ready", {30'd0, busy, s_ready}, 32'd3);
        for (int i = 0; i < 3; i++) send(prog[i], i == 2);
        chk("hold_last_strobe", {31'd0, imem_wr_en}, 32'd1);
        chk("hold_last_addr", imem_addr, 32'd8);
        chk("hold_last_mem", {mem_wr_en, mem_op, mem_addr[27:0]}, {1'b1, 3'b010, 28'd8});
        chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
        chk("hold_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        k = 0;
        while (!cpu_resetn && k < 20) begin @(posedge clk); #1; k++; end
        chk("hold_cycles", 32'(k), 32'd4);
        chk("run_done_busy", {30'd0, done, busy}, 32'd2);
        chk("boot_nwrites", 32'(wa_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("boot_addr", wa_q[i], 32'(4 * i));
            chk("boot_imem", imem_m[i], prog[i]);
        end
        chk("boot_dmem_w2", {dmem_m[11], dmem_m[10], dmem_m[9], dmem_m[8]}, prog[2]);

        // reload from RUN with s_valid toggling
        pulse_start();
        chk("reload_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        wa_q.delete(); wd_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(32'hA000_0000 | 32'(i), i == 5);
            if (i != 5) begin @(posedge clk); #1; end
        end
        wait_run("toggle_run");
        chk("toggle_nwrites", 32'(wa_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("toggle_addr", wa_q[i], 32'(4 * i));
            chk("toggle_data", wd_q[i], 32'hA000_0000 | 32'(i));
        end

        // single-word reload updates imem word 0
        pulse_start();
        send(32'hDEAD_BEEF, 1);
        wait_run("single_run");
        chk("single_imem0", imem_m[0], 32'hDEAD_BEEF);

        // cpu pass-through in RUN
        for (int i = 0; i < 4; i++) begin
            cpu_mem_wr_en = tbl[i].wr; cpu_mem_op = tbl[i].op;
            cpu_mem_addr = tbl[i].addr; cpu_mem_data_in = tbl[i].data;
            #1;
            chk("pt_wr_en", {31'd0, mem_wr_en}, {31'd0, tbl[i].exp_wr});
            chk("pt_op", {29'd0, mem_op}, {29'd0, tbl[i].exp_op});
            chk("pt_addr", mem_addr, tbl[i].exp_addr);
            chk("pt_data", mem_data_in, tbl[i].exp_data);
            chk("pt_imem_wr_en", {31'd0, imem_wr_en}, 32'd0);
            @(posedge clk); #1;
        end
        cpu_mem_wr_en = 0;
        chk("pt_mem512", {24'd0, dmem_m[512]}, 32'h69);
        chk("pt_mem20", {dmem_m[35], dmem_m[34], dmem_m[33], dmem_m[32]}, 32'hCAFE_F00D);

        // capacity overflow: 257 words into 1024 bytes
        pulse_start();
        wa_q.delete(); wd_q.delete();
        for (int i = 0; i < 257; i++) send(32'(i), i == 256);
        chk("ovf_err_set", {31'd0, err}, 32'd1);
        wait_run("ovf_run");
        chk("ovf_nwrites", 32'(wa_q.size()), 32'd256);
        chk("ovf_last_addr", wa_q[255], 32'h3FC);
        chk("ovf_last_data", wd_q[255], 32'd255);
        chk("ovf_imem0", imem_m[0], 32'd0);
        chk("ovf_err_run", {31'd0, err}, 32'd1);
        pulse_start();
        chk("ovf_err_clear", {31'd0, err}, 32'd0);

        // reset in the middle of LOAD
        wa_q.delete(); wd_q.delete();
        send(32'h11, 0);
        send(32'h22, 0);
        @(posedge clk); #1;
        chk("mid_nwrites", 32'(wa_q.size()), 32'd2);
        s_valid = 1; s_data = 32'h33; resetn = 0;
        @(posedge clk); #1;
        chk("mid_rst_strobe", {31'd0, imem_wr_en}, 32'd0);
        chk("mid_rst_state", {28'd0, cpu_resetn, busy, s_ready, done}, 32'd0);
        resetn = 1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 0;
        chk("mid_idle_nwrites", 32'(wa_q.size()), 32'd2);
        chk("mid_idle_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        send(32'h44, 1);
        @(posedge clk); #1;
        chk("mid_restart_n", 32'(wa_q.size()), 32'd3);
        chk("mid_restart_addr", wa_q[2], 32'd0);
        chk("mid_restart_data", wd_q[2], 32'h44);
        wait_run("mid_restart_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
